mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Pipeline stage directly downstream of the execute stage.
- Consumes op, memAddr, memData and the regc write-back triple produced by execute.
- Performs word loads/stores over a req/ack data-memory bus, stalling upstream while the access is outstanding, then hands a registered result to write-back.
- Non-memory ops pass through with one cycle of latency.

Parameters:
TIMEOUT_CYCLES, 16, cycles mem_req may stay high without mem_ack before bus-error abort (min 2)
CNT_W, 5, width of the timeout counter; must satisfy 2**CNT_W > TIMEOUT_CYCLES

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
valid_i  input  1  execute-stage outputs valid this cycle
op_i  input  6  opcode from execute; `Lw / `Sw (define.v) are memory ops
memAddr_i  input  32  byte address from execute
memData_i  input  32  store data from execute
regcData_i  input  32  execute result
regcWrite_i  input  1  execute write-enable
regcAddr_i  input  5  destination register
flush_i  input  1  exception/interrupt flush (cause[10] path)
stall  output  1  hold upstream stages and their outputs
mem_req  output  1  data-memory request
mem_we  output  1  1 = store, 0 = load
mem_addr  output  32  memory address
mem_wdata  output  32  store data
mem_ack  input  1  memory completion, single-cycle pulse
mem_rdata  input  32  load data, valid with mem_ack
valid_o  output  1  write-back outputs valid (one-cycle pulse per instruction)
regcData  output  32  write-back data
regcWrite  output  1  write-back enable
regcAddr  output  5  write-back register
excptype  output  32  exception code to write-back/CP0; 0 = none

Behaviour:
- Reset (async, any state): state=IDLE, counter=0, all outputs 0.
- States: IDLE, BUSY.
- IDLE, valid_i, non-mem op: next edge regcData/regcWrite/regcAddr <= inputs, valid_o<=1, excptype<=0. stall=0.
- IDLE, valid_i, `Lw or `Sw: combinational stall=1. Next edge: latch addr/data/we/regcAddr/regcWrite; mem_req<=1; counter<=0; state<=BUSY; valid_o<=0.
- IDLE, valid_i=0: valid_o<=0, other outputs hold.
- BUSY: mem_req, mem_we, mem_addr, mem_wdata held stable until ack, timeout or flush. stall=1 except in the ack cycle. Counter increments each cycle without ack.
- BUSY, mem_ack=1:
  - Same-cycle stall=0, so upstream advances at that edge.
  - Next edge: mem_req<=0, state<=IDLE, valid_o<=1.
  - Load: regcData<=mem_rdata, regcWrite<=latched regcWrite.
  - Store: regcWrite<=0.
- Timeout (BUSY, no ack, counter==TIMEOUT_CYCLES-1): stall=0 that cycle. Next edge: mem_req<=0, state<=IDLE, valid_o<=1, regcWrite<=0, excptype<=32'h00000010.
- flush_i (any state, highest priority over ack/timeout/new op): next edge mem_req<=0, state<=IDLE, valid_o<=0, regcWrite<=0, excptype<=0. stall=0 during flush.
  - Store acked in the flush cycle is committed in memory but not reported.
- mem_ack in IDLE: ignored.
- A memory op arriving in the ack cycle is accepted in IDLE on the following cycle; upstream holds it via stall until then.
- Minimum memory-op latency: 2 cycles (request edge + ack edge) when ack arrives in the first BUSY cycle.

Optional Feature:
MEM_ALIGN_CHECK_EN
- Defined: in IDLE, a memory op with memAddr_i[1:0]!=0 issues no request and takes no stall. Next edge: valid_o<=1, regcWrite<=0, excptype<=32'h00000004 for `Lw (AdEL) or 32'h00000005 for `Sw (AdES).
- Undefined: address bits [1:0] are forced to 0 on mem_addr; no alignment exception.

Test Plan:
- Reset mid-BUSY (mem_req=1): assert rst -> mem_req, stall, valid_o, regcWrite all 0 immediately (no clock); state IDLE.
- `Add pass-through, regcData_i=32'h5, regcAddr_i=3, regcWrite_i=1 -> one edge later valid_o=1, regcData=5, regcAddr=3, regcWrite=1; stall never high.
- `Lw addr 32'h100, ack after 3 BUSY cycles with rdata=32'hDEADBEEF -> mem_req high 3 cycles, mem_we=0, stall high until ack cycle, then valid_o=1, regcData=32'hDEADBEEF, regcWrite=1.
- `Sw addr 32'h40, data 32'h12345678, ack in first BUSY cycle -> mem_we=1, mem_wdata=32'h12345678, valid_o=1, regcWrite=0, excptype=0.
- `Lw with no ack, TIMEOUT_CYCLES=16 -> mem_req drops after 16 cycles, valid_o=1, regcWrite=0, excptype=32'h10.
- flush_i coincident with mem_ack on `Lw -> valid_o stays 0, regcWrite=0, state IDLE. With MEM_ALIGN_CHECK_EN, `Sw addr 32'h42 -> no mem_req, excptype=32'h5.

Source files
------------

// File: rtl/mem_access_stage_if.sv
// Data-memory req/ack bus between the memory-access stage (master) and data memory (slave).
interface mem_access_stage_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_ack, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_ack, mem_rdata
   );
endinterface

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: word loads/stores over a req/ack bus with bus-error timeout.
// Optional MEM_ALIGN_CHECK_EN raises AdEL/AdES on misaligned addresses instead of masking them.
module mem_access_stage #(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_W          = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                valid_i,
   input  logic [5:0]          op_i,
   input  logic [31:0]         memAddr_i,
   input  logic [31:0]         memData_i,
   input  logic [31:0]         regcData_i,
   input  logic                regcWrite_i,
   input  logic [4:0]          regcAddr_i,
   input  logic                flush_i,
   output logic                stall,
   mem_access_stage_if.master  mem,
   output logic                valid_o,
   output logic [31:0]         regcData,
   output logic                regcWrite,
   output logic [4:0]          regcAddr,
   output logic [31:0]         excptype
);
   localparam logic [5:0]       OP_LW       = 6'b100011;
   localparam logic [5:0]       OP_SW       = 6'b101011;
   localparam logic [31:0]      EXC_NONE    = 32'h0000_0000;
   localparam logic [31:0]      EXC_ADEL    = 32'h0000_0004;
   localparam logic [31:0]      EXC_ADES    = 32'h0000_0005;
   localparam logic [31:0]      EXC_TIMEOUT = 32'h0000_0010;
   localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   state_t           state_r;
   logic [CNT_W-1:0] cnt_r;
   logic             lat_write_r;
   logic [4:0]       lat_addr_r;

   logic is_lw_s;
   logic is_sw_s;
   logic is_mem_s;
   logic misalign_s;
   logic accept_mem_s;
   logic timeout_s;

   assign is_lw_s      = (op_i == OP_LW);
   assign is_sw_s      = (op_i == OP_SW);
   assign is_mem_s     = is_lw_s | is_sw_s;
`ifdef MEM_ALIGN_CHECK_EN
   assign misalign_s   = is_mem_s & (memAddr_i[1:0] != 2'b00);
`else
   assign misalign_s   = 1'b0;
`endif
   assign accept_mem_s = valid_i & is_mem_s & ~misalign_s;
   assign timeout_s    = (cnt_r == CNT_LAST);

   // Upstream hold: released by flush, by the ack cycle and by the timeout cycle.
   always_comb begin
      stall = 1'b0;
      if (rst || flush_i) begin
         stall = 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: stall = accept_mem_s;
            ST_BUSY: stall = ~(mem.mem_ack | timeout_s);
            default: stall = 1'b0;
         endcase
      end
   end

   // Stage state, bus request and registered write-back outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r       <= ST_IDLE;
         cnt_r         <= '0;
         lat_write_r   <= 1'b0;
         lat_addr_r    <= 5'd0;
         mem.mem_req   <= 1'b0;
         mem.mem_we    <= 1'b0;
         mem.mem_addr  <= 32'h0000_0000;
         mem.mem_wdata <= 32'h0000_0000;
         valid_o       <= 1'b0;
         regcData      <= 32'h0000_0000;
         regcWrite     <= 1'b0;
         regcAddr      <= 5'd0;
         excptype      <= EXC_NONE;
      end else if (flush_i) begin
         // Flush wins over everything; a store acked here is already in memory but goes unreported.
         state_r     <= ST_IDLE;
         cnt_r       <= '0;
         mem.mem_req <= 1'b0;
         valid_o     <= 1'b0;
         regcWrite   <= 1'b0;
         excptype    <= EXC_NONE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (valid_i && misalign_s) begin
                  valid_o   <= 1'b1;
                  regcWrite <= 1'b0;
                  regcAddr  <= regcAddr_i;
                  excptype  <= is_lw_s ? EXC_ADEL : EXC_ADES;
               end else if (accept_mem_s) begin
                  state_r       <= ST_BUSY;
                  cnt_r         <= '0;
                  mem.mem_req   <= 1'b1;
                  mem.mem_we    <= is_sw_s;
                  mem.mem_addr  <= memAddr_i & 32'hFFFF_FFFC;
                  mem.mem_wdata <= memData_i;
                  lat_write_r   <= regcWrite_i;
                  lat_addr_r    <= regcAddr_i;
                  valid_o       <= 1'b0;
               end else if (valid_i) begin
                  valid_o   <= 1'b1;
                  regcData  <= regcData_i;
                  regcWrite <= regcWrite_i;
                  regcAddr  <= regcAddr_i;
                  excptype  <= EXC_NONE;
               end else begin
                  valid_o <= 1'b0;
               end
            end
            ST_BUSY: begin
               if (mem.mem_ack) begin
                  state_r     <= ST_IDLE;
                  mem.mem_req <= 1'b0;
                  valid_o     <= 1'b1;
                  regcAddr    <= lat_addr_r;
                  excptype    <= EXC_NONE;
                  if (mem.mem_we) begin
                     regcWrite <= 1'b0;
                  end else begin
                     regcData  <= mem.mem_rdata;
                     regcWrite <= lat_write_r;
                  end
               end else if (timeout_s) begin
                  state_r     <= ST_IDLE;
                  mem.mem_req <= 1'b0;
                  valid_o     <= 1'b1;
                  regcWrite   <= 1'b0;
                  regcAddr    <= lat_addr_r;
                  excptype    <= EXC_TIMEOUT;
               end else begin
                  cnt_r   <= cnt_r + CNT_W'(1);
                  valid_o <= 1'b0;
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               mem.mem_req <= 1'b0;
               valid_o     <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized self-checking bench for mem_access_stage with a transaction-level memory model.
module tb_mem_access_stage;
   localparam int         TO     = 16;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_SW  = 6'b101011;
   localparam logic [5:0] OP_ADD = 6'b100000;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_i;
   logic [5:0]  op_i;
   logic [31:0] memAddr_i;
   logic [31:0] memData_i;
   logic [31:0] regcData_i;
   logic        regcWrite_i;
   logic [4:0]  regcAddr_i;
   logic        flush_i;
   logic        stall;
   logic        valid_o;
   logic [31:0] regcData;
   logic        regcWrite;
   logic [4:0]  regcAddr;
   logic [31:0] excptype;

   mem_access_stage_if bus();

   mem_access_stage #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
      .clk(clk), .rst(rst), .valid_i(valid_i), .op_i(op_i),
      .memAddr_i(memAddr_i), .memData_i(memData_i), .regcData_i(regcData_i),
      .regcWrite_i(regcWrite_i), .regcAddr_i(regcAddr_i), .flush_i(flush_i),
      .stall(stall), .mem(bus), .valid_o(valid_o), .regcData(regcData),
      .regcWrite(regcWrite), .regcAddr(regcAddr), .excptype(excptype)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] mem_model [logic [31:0]];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem_model.exists(a)) return mem_model[a];
      return a ^ 32'h5A5A_0F0F;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Idle cycles with stray acks, which the stage must ignore.
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         valid_i     = 1'b0;
         bus.mem_ack = 1'($urandom_range(0, 1));
         #1;
         check_val("idle_stall", 32'(stall), 32'd0);
         tick();
         bus.mem_ack = 1'b0;
         check_val("idle_req", 32'(bus.mem_req), 32'd0);
         check_val("idle_valid", 32'(valid_o), 32'd0);
      end
   endtask

   // One instruction from issue to result. ack_at: ack in BUSY cycle ack_at-1 (beyond TO means never).
   // flush_at: -1 none, 0 in the issue cycle, k>0 in BUSY cycle k-1.
   task automatic do_op(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] xdata, input logic [4:0] rd, input logic wr,
                        input int ack_at, input int flush_at);
      logic        is_ld, is_mem, misal, acked, flushed, timed;
      logic [31:0] waddr, rdat;
      is_ld   = (op == OP_LW);
      is_mem  = (op == OP_LW) || (op == OP_SW);
`ifdef MEM_ALIGN_CHECK_EN
      misal   = is_mem && (addr[1:0] != 2'b00);
`else
      misal   = 1'b0;
`endif
      waddr   = {addr[31:2], 2'b00};
      rdat    = 32'h0;
      acked   = 1'b0;
      flushed = 1'b0;
      timed   = 1'b0;

      valid_i = 1'b1; op_i = op; memAddr_i = addr; memData_i = wdata;
      regcData_i = xdata; regcAddr_i = rd; regcWrite_i = wr;
      flush_i = (flush_at == 0);
      #1;
      check_val("issue_stall", 32'(stall), 32'(is_mem && !misal && flush_at != 0));
      tick();
      if (flush_at == 0) begin
         valid_i = 1'b0; flush_i = 1'b0;
         check_val("flush0_valid", 32'(valid_o), 32'd0);
         check_val("flush0_req", 32'(bus.mem_req), 32'd0);
         check_val("flush0_wr", 32'(regcWrite), 32'd0);
         check_val("flush0_exc", excptype, 32'd0);
         return;
      end
      if (!is_mem || misal) begin
         valid_i = 1'b0;
         check_val("pt_valid", 32'(valid_o), 32'd1);
         check_val("pt_req", 32'(bus.mem_req), 32'd0);
         check_val("pt_addr", 32'(regcAddr), 32'(rd));
         if (misal) begin
            check_val("adex_wr", 32'(regcWrite), 32'd0);
            check_val("adex_exc", excptype, is_ld ? 32'h4 : 32'h5);
         end else begin
            check_val("pt_data", regcData, xdata);
            check_val("pt_wr", 32'(regcWrite), 32'(wr));
            check_val("pt_exc", excptype, 32'd0);
         end
         return;
      end
      // Upstream keeps presenting the same instruction while stalled.
      for (int k = 0; k < TO; k++) begin
         check_val("busy_req", 32'(bus.mem_req), 32'd1);
         check_val("busy_we", 32'(bus.mem_we), 32'(!is_ld));
         check_val("busy_addr", bus.mem_addr, waddr);
         check_val("busy_valid", 32'(valid_o), 32'd0);
         if (!is_ld) check_val("busy_wdata", bus.mem_wdata, wdata);
         acked   = (k == ack_at - 1);
         flushed = (k == flush_at - 1);
         timed   = (k == TO - 1) && !acked;
         bus.mem_ack   = acked;
         flush_i       = flushed;
         bus.mem_rdata = acked ? mem_rd(waddr) : $urandom;
         rdat          = bus.mem_rdata;
         #1;
         check_val("busy_stall", 32'(stall), 32'(!(acked || flushed || timed)));
         tick();
         bus.mem_ack = 1'b0;
         flush_i     = 1'b0;
         if (acked || flushed || timed) break;
      end
      valid_i = 1'b0;
      if (acked && !is_ld) mem_model[waddr] = wdata;
      check_val("done_req", 32'(bus.mem_req), 32'd0);
      if (flushed) begin
         check_val("flush_valid", 32'(valid_o), 32'd0);
         check_val("flush_wr", 32'(regcWrite), 32'd0);
         check_val("flush_exc", excptype, 32'd0);
      end else if (acked) begin
         check_val("ack_valid", 32'(valid_o), 32'd1);
         check_val("ack_exc", excptype, 32'd0);
         check_val("ack_wr", 32'(regcWrite), is_ld ? 32'(wr) : 32'd0);
         if (is_ld) begin
            check_val("ld_data", regcData, rdat);
            check_val("ld_addr", 32'(regcAddr), 32'(rd));
         end
      end else begin
         check_val("to_valid", 32'(valid_o), 32'd1);
         check_val("to_wr", 32'(regcWrite), 32'd0);
         check_val("to_exc", excptype, 32'h10);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0]  op;
      logic [31:0] addr;
      int          sel, ack_at, flush_at;

      rst = 1'b1; valid_i = 1'b0; op_i = 6'd0; memAddr_i = 32'h0; memData_i = 32'h0;
      regcData_i = 32'h0; regcWrite_i = 1'b0; regcAddr_i = 5'd0; flush_i = 1'b0;
      bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_req", 32'(bus.mem_req), 32'd0);
      check_val("rst_stall", 32'(stall), 32'd0);
      check_val("rst_valid", 32'(valid_o), 32'd0);
      check_val("rst_wr", 32'(regcWrite), 32'd0);
      check_val("rst_data", regcData, 32'd0);
      check_val("rst_exc", excptype, 32'd0);
      check_val("rst_maddr", bus.mem_addr, 32'd0);
      rst = 1'b0;
      tick();

      // Asynchronous reset in the middle of an outstanding load.
      valid_i = 1'b1; op_i = OP_LW; memAddr_i = 32'h80; regcAddr_i = 5'd4; regcWrite_i = 1'b1;
      tick();
      check_val("pre_rst_req", 32'(bus.mem_req), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check_val("async_req", 32'(bus.mem_req), 32'd0);
      check_val("async_stall", 32'(stall), 32'd0);
      check_val("async_valid", 32'(valid_o), 32'd0);
      check_val("async_wr", 32'(regcWrite), 32'd0);
      valid_i = 1'b0;
      tick();
      rst = 1'b0;
      idle(2);

      do_op(OP_ADD, 32'h0, 32'h0, 32'h5, 5'd3, 1'b1, 0, -1);
      mem_model[32'h100] = 32'hDEAD_BEEF;
      do_op(OP_LW, 32'h100, 32'h0, 32'h0, 5'd7, 1'b1, 3, -1);
      check_val("lw_const", regcData, 32'hDEAD_BEEF);
      do_op(OP_SW, 32'h40, 32'h1234_5678, 32'h0, 5'd9, 1'b1, 1, -1);
      do_op(OP_LW, 32'h40, 32'h0, 32'h0, 5'd10, 1'b1, 1, -1);
      check_val("sw_readback", regcData, 32'h1234_5678);
      do_op(OP_LW, 32'h44, 32'h0, 32'h0, 5'd11, 1'b1, TO + 5, -1);
      do_op(OP_LW, 32'h100, 32'h0, 32'h0, 5'd12, 1'b1, 2, 2);
      do_op(OP_SW, 32'h42, 32'hAAAA_5555, 32'h0, 5'd1, 1'b1, 1, -1);
      do_op(OP_LW, 32'h43, 32'h0, 32'h0, 5'd2, 1'b1, 2, -1);
      idle(1);

      repeat (300) begin
         sel = $urandom_range(0, 9);
         if (sel < 4)      op = OP_LW;
         else if (sel < 7) op = OP_SW;
         else if (sel == 7) op = OP_ADD;
         else begin
            op = 6'($urandom);
            while (op == OP_LW || op == OP_SW) op = 6'($urandom);
         end
         addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
         if ($urandom_range(0, 7) == 0) addr[1:0] = 2'($urandom_range(1, 3));
         ack_at   = ($urandom_range(0, 9) == 0) ? TO + 5 : $urandom_range(1, 6);
         flush_at = ($urandom_range(0, 11) == 0) ? $urandom_range(0, 4) : -1;
         do_op(op, addr, $urandom, $urandom, 5'($urandom), 1'($urandom), ack_at, flush_at);
         idle($urandom_range(0, 2));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
